// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control unit:
// FSM states, opcodes, ALU codes and datapath mux selects.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from ALUOp and instruction fields.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FN: begin
                case (funct3)
                    // only R-type (op5=1) can encode sub
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-FSM control unit for a multicycle RV32 subset datapath.
// Only the state is registered; every output decodes from it.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       retire
);

    state_e cur, nxt;
    logic [1:0] aluop;
    logic pcupdate, branch, irw, memw, regw;

    assign state = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= S_FETCH;
        else          cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (op == OP_LOAD || op == OP_STORE) nxt = S_MEMADR;
                else if (op == OP_RTYPE)             nxt = S_EXECUTER;
                else if (op == OP_ITYPE)             nxt = S_EXECUTEI;
                else if (op == OP_JAL)               nxt = S_JAL;
                else if (op == OP_BEQ)               nxt = S_BEQ;
                else if (ILLEGAL_TRAP)               nxt = S_HALT;
                else                                 nxt = S_FETCH;
            end
            S_MEMADR:   nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = S_MEMWB;
            S_EXECUTER: nxt = S_ALUWB;
            S_EXECUTEI: nxt = S_ALUWB;
            S_JAL:      nxt = S_ALUWB;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        irw       = 1'b0;
        memw      = 1'b0;
        regw      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        retire    = 1'b0;
        case (cur)
            S_FETCH: begin
                irw       = 1'b1;
                pcupdate  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                regw      = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
                retire = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_FN;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FN;
            end
            S_ALUWB: begin
                regw   = 1'b1;
                retire = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_STORE: ImmSrc = IMM_S;
            OP_BEQ:   ImmSrc = IMM_B;
            OP_JAL:   ImmSrc = IMM_J;
            default:  ImmSrc = IMM_I;
        endcase
    end

    // write enables are gated so reset blocks them before the state settles
    assign PCWrite  = (pcupdate | (branch & zero)) & reset_n;
    assign IRWrite  = irw  & reset_n;
    assign MemWrite = memw & reset_n;
    assign RegWrite = regw & reset_n;

    alu_decoder u_alu_decoder (
        .ALUOp      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed + random instruction stream
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       mw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ret;
    } exp_t;

    logic clk = 1'b0;
    logic [1:0] rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic funct7b5, zero;

    logic [1:0] pcw, adr, irw, mw, rw, ret;
    logic [1:0] rs [2];
    logic [1:0] sa [2];
    logic [1:0] sb [2];
    logic [1:0] imm [2];
    logic [2:0] alu [2];
    logic [3:0] st [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset_n(rst[0]), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .PCWrite(pcw[0]),
        .AdrSrc(adr[0]), .IRWrite(irw[0]), .MemWrite(mw[0]),
        .RegWrite(rw[0]), .ResultSrc(rs[0]), .ALUSrcA(sa[0]),
        .ALUSrcB(sb[0]), .ImmSrc(imm[0]), .ALUControl(alu[0]),
        .state(st[0]), .retire(ret[0])
    );

    multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset_n(rst[1]), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .PCWrite(pcw[1]),
        .AdrSrc(adr[1]), .IRWrite(irw[1]), .MemWrite(mw[1]),
        .RegWrite(rw[1]), .ResultSrc(rs[1]), .ALUSrcA(sa[1]),
        .ALUSrcB(sb[1]), .ImmSrc(imm[1]), .ALUControl(alu[1]),
        .state(st[1]), .retire(ret[1])
    );

    function automatic exp_t obs(int i);
        exp_t e;
        e.st = st[i];   e.pcw = pcw[i]; e.adr = adr[i];
        e.irw = irw[i]; e.mw = mw[i];   e.rw = rw[i];
        e.rs = rs[i];   e.sa = sa[i];   e.sb = sb[i];
        e.imm = imm[i]; e.alu = alu[i]; e.ret = ret[i];
        return e;
    endfunction

    function automatic logic known(logic [6:0] o);
        return o == OP_LOAD || o == OP_STORE || o == OP_RTYPE ||
               o == OP_ITYPE || o == OP_JAL || o == OP_BEQ;
    endfunction

    // arithmetic op the instruction asks for
    function automatic logic [2:0] fn_of(logic [6:0] o, logic [2:0] f3,
                                         logic f7);
        case (f3)
            3'b000:  return (o == OP_RTYPE && f7) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // expected step sequence of one instruction
    task automatic seq_of(input logic [6:0] o, input bit trap,
                          output state_e q[$]);
        q = {S_FETCH, S_DECODE};
        if (o == OP_LOAD)       q = {q, S_MEMADR, S_MEMREAD, S_MEMWB};
        else if (o == OP_STORE) q = {q, S_MEMADR, S_MEMWRITE};
        else if (o == OP_RTYPE) q = {q, S_EXECUTER, S_ALUWB};
        else if (o == OP_ITYPE) q = {q, S_EXECUTEI, S_ALUWB};
        else if (o == OP_JAL)   q = {q, S_JAL, S_ALUWB};
        else if (o == OP_BEQ)   q = {q, S_BEQ};
        else if (trap)          q = {q, S_HALT};
    endtask

    function automatic exp_t model(state_e s, logic [6:0] o,
                                   logic [2:0] f3, logic f7, logic z);
        exp_t e = '0;
        e.st  = s;
        e.imm = (o == OP_STORE) ? IMM_S : (o == OP_BEQ) ? IMM_B :
                (o == OP_JAL) ? IMM_J : IMM_I;
        e.alu = ALU_ADD;
        case (s)
            S_FETCH: begin
                e.irw = 1; e.pcw = 1; e.sb = SRCB_FOUR; e.rs = RES_ALU;
            end
            S_DECODE:   begin e.sa = SRCA_OLDPC; e.sb = SRCB_IMM; end
            S_MEMADR:   begin e.sa = SRCA_RS1; e.sb = SRCB_IMM; end
            S_MEMREAD:  e.adr = 1;
            S_MEMWB:    begin e.rs = RES_DATA; e.rw = 1; e.ret = 1; end
            S_MEMWRITE: begin e.adr = 1; e.mw = 1; e.ret = 1; end
            S_EXECUTER: begin e.sa = SRCA_RS1; e.alu = fn_of(o, f3, f7); end
            S_EXECUTEI: begin
                e.sa = SRCA_RS1; e.sb = SRCB_IMM; e.alu = fn_of(o, f3, f7);
            end
            S_ALUWB:    begin e.rw = 1; e.ret = 1; end
            S_BEQ: begin
                e.sa = SRCA_RS1; e.alu = ALU_SUB; e.pcw = z; e.ret = 1;
            end
            S_JAL: begin
                e.sa = SRCA_OLDPC; e.sb = SRCB_FOUR; e.pcw = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t rst_model(logic [6:0] o);
        exp_t e = model(S_FETCH, o, 3'b000, 1'b0, 1'b0);
        e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input exp_t got, input exp_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // zm: -1 random zero flag each cycle, else fixed; n: cycles to run
    task automatic run(input int d, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input int zm, input int n,
                       input string tag);
        state_e q[$];
        seq_of(o, d == 1, q);
        if (n == 0) n = q.size();
        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            zero = (zm < 0) ? 1'($urandom) : 1'(zm);
            #1;
            chk($sformatf("%s[%0d]", tag, i), obs(d),
                model(q[i], o, f3, f7, zero));
        end
    endtask

    task automatic instr(input int d, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input int zm, input string tag);
        run(d, o, f3, f7, zm, 0, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] ro;
        rst = 2'b00;
        op = OP_LOAD; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
        #3;
        chk("reset0", obs(0), rst_model(OP_LOAD));
        chk("reset1", obs(1), rst_model(OP_LOAD));
        @(negedge clk);
        rst[0] = 1'b1;

        instr(0, OP_LOAD,  3'b010, 1'b0, -1, "lw");
        instr(0, OP_STORE, 3'b010, 1'b1, -1, "sw");
        instr(0, OP_RTYPE, 3'b000, 1'b1, -1, "sub");
        instr(0, OP_RTYPE, 3'b111, 1'b0, -1, "and");
        instr(0, OP_RTYPE, 3'b110, 1'b0, -1, "or");
        instr(0, OP_RTYPE, 3'b010, 1'b0, -1, "slt");
        instr(0, OP_ITYPE, 3'b000, 1'b1, -1, "addi");
        instr(0, OP_JAL,   3'b101, 1'b0, -1, "jal");
        instr(0, OP_BEQ,   3'b000, 1'b0,  1, "beq_taken");
        instr(0, OP_BEQ,   3'b000, 1'b0,  0, "beq_not");
        instr(0, 7'h7f,    3'b000, 1'b0, -1, "illegal");
        instr(0, OP_LOAD,  3'b010, 1'b0, -1, "lw_after_ill");

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 6))
                0: ro = OP_LOAD;
                1: ro = OP_STORE;
                2: ro = OP_RTYPE;
                3: ro = OP_ITYPE;
                4: ro = OP_JAL;
                5: ro = OP_BEQ;
                default: begin
                    do ro = 7'($urandom); while (known(ro));
                end
            endcase
            instr(0, ro, 3'($urandom), 1'($urandom), -1,
                  $sformatf("rnd%0d_op%02h", k, ro));
        end

        run(0, OP_STORE, 3'b010, 1'b0, -1, 4, "sw_abort");
        #1;
        rst[0] = 1'b0;
        #1;
        chk("rst_mid_memwrite", obs(0), rst_model(OP_STORE));
        @(negedge clk);
        rst[0] = 1'b1;
        instr(0, OP_RTYPE, 3'b000, 1'b1, -1, "resume_sub");

        @(negedge clk);
        rst[1] = 1'b1;
        run(1, 7'h7f, 3'b000, 1'b0, -1, 3, "trap");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            zero = 1'($urandom);
            #1;
            chk($sformatf("halt[%0d]", i), obs(1),
                model(S_HALT, 7'h7f, 3'b000, 1'b0, zero));
        end
        #1;
        rst[1] = 1'b0;
        #1;
        chk("rst_halt", obs(1), rst_model(7'h7f));
        @(negedge clk);
        rst[1] = 1'b1;
        instr(1, OP_LOAD, 3'b010, 1'b0, -1, "trap_lw");
        instr(1, OP_BEQ,  3'b000, 1'b0, -1, "trap_beq");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: ILLEGAL_TRAP, default 0, meaning 1 = unsupported opcode enters HALT; 0 = unsupported opcode returns to FETCH.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  instruction opcode, Instr[6:0], from the instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  output  1 each  PC enable, memory address select (0 = PC, 1 = ALU result register), IR enable, memory write, register-file write.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  result mux, ALU A mux (00 PC, 01 OldPC, 10 rs1), ALU B mux (00 rs2, 01 imm, 10 const 4), immediate format (00 I, 01 S, 10 B, 11 J).
REQ-010 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 state  output  4  current FSM state, for debug.
REQ-012 retire  output  1  high during the last cycle of each instruction.

Function
REQ-013 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT, and SHALL register only the state.
REQ-014 Unlisted outputs SHALL be 0 in every state.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-015 The block SHALL drive PCWrite = PCUpdate | (Branch & zero), combinationally within the same cycle.
REQ-016 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: op 0000011 or 0100011 ->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1101111->JAL; 1100011->BEQ; any other op ->HALT if ILLEGAL_TRAP=1, else ->FETCH.
- MEMADR: op 0000011->MEMREAD, otherwise ->MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER, EXECUTEI, JAL ->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ ->FETCH.
- HALT->HALT.
REQ-017 ImmSrc SHALL decode combinationally from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-018 ALUControl SHALL decode as follows.
- ALUOp 00 -> add.
- ALUOp 01 -> sub.
- ALUOp 10, funct3 000 -> sub if op[5]&funct7b5, else add.
- ALUOp 10, funct3 010 -> slt; 110 -> or; 111 -> and.
- ALUOp 10, any other funct3 -> add.
REQ-019 retire SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB and BEQ.
REQ-020 Latencies SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles; illegal with ILLEGAL_TRAP=0 takes 2 cycles with no register or memory write.
REQ-021 While in HALT, every write enable SHALL be 0.

Reset
REQ-022 reset_n low SHALL set state to FETCH asynchronously, and the block SHALL leave reset in FETCH on the first rising clk edge with reset_n high.
REQ-023 While reset_n is low, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0; other outputs SHALL follow FETCH decoding.
REQ-024 Reset asserted in any state, including mid-instruction or HALT, SHALL abort the instruction with no further writes.

Structure
REQ-025 A shared package SHALL hold the state enum (4 bits), the opcode constants, the ALUControl codes, and the mux-select codes for ResultSrc, ALUSrcA, ALUSrcB and ImmSrc.
REQ-026 The ALU decoder SHALL be one combinational sub-module, alu_decoder (inputs ALUOp, funct3, op5, funct7b5; output ALUControl); all other logic SHALL stay in multicycle_control.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- lw (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; retire=1 in cycle 5.
- sw (op 0100011): MemWrite=1 only in cycle 4; AdrSrc=1; ImmSrc=01 throughout.
- R-type sub (funct3 000, funct7b5=1): ALUControl=001 in EXECUTER. R-type and (funct3 111): ALUControl=010. I-type addi with funct7b5=1: ALUControl=000.
- beq with zero=1: PCWrite=1 in cycle 3. beq with zero=0: PCWrite=0 in cycle 3. Both return to FETCH.
- op 1111111: with ILLEGAL_TRAP=0, returns to FETCH after DECODE with no writes; with ILLEGAL_TRAP=1, sticks in HALT until reset_n pulses low.
- reset_n dropped mid-MEMWRITE: state=FETCH immediately, MemWrite=0 without a clock edge, and fetch resumes after release.
